// File: rtl/msg_arbiter.sv
// Merges keyboard and autoplay message strobes into one paced message stream.
// Keyboard wins arbitration and suppresses autoplay for a hold window afterwards.
module msg_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 8,
  parameter int HOLD_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play_en,
  input  logic       strb_kbd,
  input  logic [7:0] msg_kbd,
  input  logic       strb_auto,
  input  logic [7:0] msg_auto,
  output logic       clk_msg,
  output logic [7:0] msg,
  output logic       auto_en,
  output logic       ovf_kbd,
  output logic       ovf_auto
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(PULSE_CYCLES + GAP_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] PULSE_LD  = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD    = TW'(GAP_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LD   = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  logic          r_warm, r_run;
  logic          r_k_s1, r_k_s2, r_k_prev, r_k_arm;
  logic          r_a_s1, r_a_s2, r_a_prev, r_a_arm;
  logic [7:0]    r_k_mem [FIFO_DEPTH];
  logic [7:0]    r_a_mem [FIFO_DEPTH];
  logic [AW-1:0] r_k_wp, r_k_rp, r_a_wp, r_a_rp;
  logic [CW-1:0] r_k_cnt, r_a_cnt;
  logic          r_ovf_k, r_ovf_a;
  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [HW-1:0] r_hold;
  logic          r_cur_kbd, r_clk_msg;
  logic [7:0]    r_msg;

  logic w_k_edge, w_a_edge, w_k_full, w_a_full, w_k_empty, w_a_empty;
  logic w_k_pop, w_a_pop, w_k_wr, w_a_wr, w_hold_active, w_auto_en;

  // Edges are armed only after the strobe has been seen low, so a strobe
  // already high when reset releases cannot push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_warm <= 1'b0; r_run <= 1'b0;
      r_k_s1 <= 1'b0; r_k_s2 <= 1'b0; r_k_prev <= 1'b0; r_k_arm <= 1'b0;
      r_a_s1 <= 1'b0; r_a_s2 <= 1'b0; r_a_prev <= 1'b0; r_a_arm <= 1'b0;
    end else begin
      r_warm   <= 1'b1;
      r_run    <= 1'b1;
      r_k_s1   <= strb_kbd;
      r_k_s2   <= r_k_s1;
      r_k_prev <= r_k_s2;
      r_k_arm  <= r_k_arm | (r_warm & ~r_k_s1);
      r_a_s1   <= strb_auto;
      r_a_s2   <= r_a_s1;
      r_a_prev <= r_a_s2;
      r_a_arm  <= r_a_arm | (r_warm & ~r_a_s1);
    end
  end

  assign w_k_edge  = r_k_s2 & ~r_k_prev & r_k_arm;
  assign w_a_edge  = r_a_s2 & ~r_a_prev & r_a_arm;
  assign w_k_full  = (r_k_cnt == FULL_CNT);
  assign w_a_full  = (r_a_cnt == FULL_CNT);
  assign w_k_empty = (r_k_cnt == '0);
  assign w_a_empty = (r_a_cnt == '0);

  assign w_hold_active = ~w_k_empty | ((r_state != S_IDLE) & r_cur_kbd) | (r_hold != '0);
  assign w_auto_en     = r_run & play_en & ~w_hold_active;

  assign w_k_pop = (r_state == S_IDLE) & ~w_k_empty;
  assign w_a_pop = (r_state == S_IDLE) & w_k_empty & ~w_a_empty & w_auto_en;
  assign w_k_wr  = w_k_edge & (~w_k_full | w_k_pop);
  assign w_a_wr  = w_a_edge & play_en & (~w_a_full | w_a_pop);

  always_ff @(posedge clk) begin
    if (w_k_wr) r_k_mem[r_k_wp] <= msg_kbd;
    if (w_a_wr) r_a_mem[r_a_wp] <= msg_auto;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k_wp <= '0; r_k_rp <= '0; r_k_cnt <= '0; r_ovf_k <= 1'b0;
    end else begin
      if (w_k_wr)  r_k_wp <= r_k_wp + AW'(1);
      if (w_k_pop) r_k_rp <= r_k_rp + AW'(1);
      case ({w_k_wr, w_k_pop})
        2'b10:   r_k_cnt <= r_k_cnt + CW'(1);
        2'b01:   r_k_cnt <= r_k_cnt - CW'(1);
        default: ;
      endcase
      if (w_k_edge & w_k_full & ~w_k_pop) r_ovf_k <= 1'b1;
    end
  end

  // With autoplay switched off the queue is flushed and new pushes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_wp <= '0; r_a_rp <= '0; r_a_cnt <= '0; r_ovf_a <= 1'b0;
    end else if (!play_en) begin
      r_a_cnt <= '0;
      r_a_rp  <= r_a_wp;
    end else begin
      if (w_a_wr)  r_a_wp <= r_a_wp + AW'(1);
      if (w_a_pop) r_a_rp <= r_a_rp + AW'(1);
      case ({w_a_wr, w_a_pop})
        2'b10:   r_a_cnt <= r_a_cnt + CW'(1);
        2'b01:   r_a_cnt <= r_a_cnt - CW'(1);
        default: ;
      endcase
      if (w_a_edge & w_a_full & ~w_a_pop) r_ovf_a <= 1'b1;
    end
  end

  // The hold counter is frozen while a keyboard message is on the wire and
  // restarts from HOLD_CYCLES when that message's gap ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE; r_timer <= '0; r_hold <= '0;
      r_cur_kbd <= 1'b0; r_clk_msg <= 1'b0; r_msg <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_k_pop) begin
            r_state   <= S_SEND;
            r_msg     <= r_k_mem[r_k_rp];
            r_clk_msg <= 1'b1;
            r_timer   <= PULSE_LD;
            r_cur_kbd <= 1'b1;
            r_hold    <= HOLD_LD;
          end else if (w_a_pop) begin
            r_state   <= S_SEND;
            r_msg     <= r_a_mem[r_a_rp];
            r_clk_msg <= 1'b1;
            r_timer   <= PULSE_LD;
            r_cur_kbd <= 1'b0;
          end else if (r_hold != '0) begin
            r_hold <= r_hold - HW'(1);
          end
        end
        S_SEND: begin
          if (r_timer == '0) begin
            r_state   <= S_GAP;
            r_clk_msg <= 1'b0;
            r_timer   <= GAP_LD;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_GAP: begin
          if (r_timer == '0) begin
            r_state <= S_IDLE;
            if (r_cur_kbd) r_hold <= HOLD_LD;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign clk_msg  = r_clk_msg;
  assign msg      = r_msg;
  assign auto_en  = w_auto_en;
  assign ovf_kbd  = r_ovf_k;
  assign ovf_auto = r_ovf_a;

endmodule

// File: tb/tb_msg_arbiter.sv
// Directed bench for msg_arbiter: vector table for single messages plus
// hand-written sequences for arbitration, overflow, flush and reset.
module tb_msg_arbiter;

  localparam int PULSE = 4;
  localparam int GAP   = 8;
  localparam int HOLD  = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       play_en = 1'b1;
  logic       strb_kbd = 1'b0;
  logic [7:0] msg_kbd = 8'h00;
  logic       strb_auto = 1'b0;
  logic [7:0] msg_auto = 8'h00;
  logic       clk_msg;
  logic [7:0] msg;
  logic       auto_en, ovf_kbd, ovf_auto;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  msg_arbiter #(.FIFO_DEPTH(4), .PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .play_en(play_en),
    .strb_kbd(strb_kbd), .msg_kbd(msg_kbd),
    .strb_auto(strb_auto), .msg_auto(msg_auto),
    .clk_msg(clk_msg), .msg(msg), .auto_en(auto_en),
    .ovf_kbd(ovf_kbd), .ovf_auto(ovf_auto)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: message order, pulse width, minimum gap
  logic prev_cm = 1'b0;
  int   hi_cnt = 0;
  int   lo_cnt = GAP;
  always @(negedge clk) begin
    if (rst) begin
      prev_cm = 1'b0;
      hi_cnt  = 0;
      lo_cnt  = GAP;
    end else begin
      if (clk_msg && !prev_cm) begin
        check("gap_min", 32'(lo_cnt >= GAP), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_msg", {24'd0, msg}, 32'hFFFF_FFFF);
        end else begin
          check("msg_order", {24'd0, msg}, {24'd0, exp_q.pop_front()});
        end
        hi_cnt = 1;
      end else if (clk_msg) begin
        hi_cnt++;
      end else if (prev_cm) begin
        check("pulse_width", hi_cnt, PULSE);
        lo_cnt = 1;
      end else begin
        lo_cnt++;
      end
      prev_cm = clk_msg;
    end
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic raise(input bit is_kbd, input logic [7:0] v);
    @(negedge clk);
    if (is_kbd) begin msg_kbd = v; strb_kbd = 1'b1; end
    else begin msg_auto = v; strb_auto = 1'b1; end
  endtask

  task automatic drop_all();
    @(negedge clk);
    strb_kbd  = 1'b0;
    strb_auto = 1'b0;
  endtask

  task automatic pulse(input bit is_kbd, input logic [7:0] v);
    raise(is_kbd, v);
    repeat (3) @(negedge clk);
    if (is_kbd) strb_kbd = 1'b0; else strb_auto = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic measure_lat(output int lat);
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (clk_msg) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    wait_cyc(PULSE + GAP + 2);
  endtask

  typedef struct {
    bit         is_kbd;
    logic [7:0] data;
    int         exp_lat;
    logic       exp_auto_en;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int lat, en_at, rise_at, hi_n;
    logic prv;

    vecs[0] = '{is_kbd: 1'b0, data: 8'hA5, exp_lat: 3, exp_auto_en: 1'b1};
    vecs[1] = '{is_kbd: 1'b0, data: 8'h5A, exp_lat: 3, exp_auto_en: 1'b1};
    vecs[2] = '{is_kbd: 1'b1, data: 8'h3C, exp_lat: 3, exp_auto_en: 1'b0};
    vecs[3] = '{is_kbd: 1'b1, data: 8'h81, exp_lat: 3, exp_auto_en: 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_clk_msg", clk_msg, 0);
    check("rst_msg", msg, 8'h00);
    check("rst_auto_en", auto_en, 0);
    check("rst_ovf_kbd", ovf_kbd, 0);
    check("rst_ovf_auto", ovf_auto, 0);
    rst = 1'b0;
    wait_cyc(1);
    check("auto_en_first_edge", auto_en, 1);
    wait_cyc(4);

    // single-message vectors
    for (int v = 0; v < 4; v++) begin
      exp_q.push_back(vecs[v].data);
      raise(vecs[v].is_kbd, vecs[v].data);
      measure_lat(lat);
      check($sformatf("latency_%0d", v), lat, vecs[v].exp_lat);
      drop_all();
      wait_cyc(14);
      check($sformatf("msg_hold_%0d", v), msg, vecs[v].data);
      check($sformatf("auto_en_after_%0d", v), auto_en, vecs[v].exp_auto_en);
    end

    // kbd and auto on the same cycle: kbd first, auto only after hold
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    @(negedge clk);
    msg_kbd = 8'h11; strb_kbd = 1'b1;
    msg_auto = 8'h22; strb_auto = 1'b1;
    measure_lat(lat);
    check("both_latency", lat, 3);
    en_at = -1; rise_at = -1; prv = 1'b1;
    for (int n = 1; n <= 1200; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin strb_kbd = 1'b0; strb_auto = 1'b0; end
      if (auto_en && en_at < 0) en_at = n;
      if (clk_msg && !prv) begin
        rise_at = n;
        break;
      end
      prv = clk_msg;
    end
    check("hold_auto_en_at", en_at, PULSE + GAP + HOLD);
    check("hold_auto_rise_at", rise_at, PULSE + GAP + HOLD + 1);
    drain(50);

    // play_en dropped with three autos queued behind a kbd hold
    exp_q.push_back(8'h44);
    raise(1'b1, 8'h44);
    measure_lat(lat);
    check("flush_kbd_latency", lat, 3);
    drop_all();
    pulse(1'b0, 8'hC0);
    pulse(1'b0, 8'hC1);
    pulse(1'b0, 8'hC2);
    @(negedge clk);
    play_en = 1'b0;
    wait_cyc(1);
    check("flush_auto_en", auto_en, 0);
    for (int i = 0; i < 6; i++) pulse(1'b0, 8'hD0 + 8'(i));
    check("flush_no_ovf_auto", ovf_auto, 0);
    wait_cyc(HOLD + 20);
    check("flush_auto_en_off", auto_en, 0);
    @(negedge clk);
    play_en = 1'b1;
    wait_cyc(40);
    check("flush_auto_en_back", auto_en, 1);
    check("flush_nothing_sent", exp_q.size(), 0);

    // six autos while blocked: four queued, overflow flagged
    exp_q.push_back(8'h77);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hB0 + 8'(i));
    raise(1'b1, 8'h77);
    measure_lat(lat);
    check("ovf_kbd_latency", lat, 3);
    drop_all();
    for (int i = 0; i < 6; i++) pulse(1'b0, 8'hB0 + 8'(i));
    wait_cyc(2);
    check("ovf_auto_set", ovf_auto, 1);
    check("ovf_kbd_clear", ovf_kbd, 0);
    drain(2000);
    check("ovf_auto_sticky", ovf_auto, 1);

    // reset asserted mid-SEND with the strobe held across release
    exp_q.push_back(8'h99);
    raise(1'b1, 8'h99);
    measure_lat(lat);
    check("rst_mid_latency", lat, 3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_clk_msg", clk_msg, 0);
    check("rst_async_msg", msg, 8'h00);
    check("rst_async_ovf_auto", ovf_auto, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hi_n = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (clk_msg) hi_n++;
    end
    check("rst_no_push_held_strobe", hi_n, 0);
    check("rst_release_auto_en", auto_en, 1);
    drop_all();
    wait_cyc(4);
    exp_q.push_back(8'h9A);
    raise(1'b1, 8'h9A);
    measure_lat(lat);
    check("rst_new_edge_latency", lat, 3);
    drop_all();
    drain(50);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
